// File: rtl/quiz_pkg.sv
// Shared constants, width helper and answer key for the quiz datapath.
package quiz_pkg;

  localparam int N_BOTOES_DEF  = 4;
  localparam int N_RODADAS_DEF = 16;
  localparam int TIMEOUT_DEF   = 5000;

  // Floor of 1 bit keeps degenerate sizes (n <= 2) from producing zero-width vectors.
  function automatic int W_RODADA(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam logic [3:0] GABARITO [N_RODADAS_DEF] = '{
    4'b0100, 4'b0010, 4'b0001, 4'b1000,
    4'b0010, 4'b0100, 4'b1000, 4'b0001,
    4'b0100, 4'b0001, 4'b0010, 4'b1000,
    4'b0001, 4'b1000, 4'b0100, 4'b0010
  };

endpackage

// File: rtl/quiz_rom.sv
// Combinational answer-key lookup; swapping the question set only touches this ROM.
module quiz_rom
  import quiz_pkg::*;
#(
  parameter int N_RODADAS = N_RODADAS_DEF,
  parameter int N_BOTOES  = N_BOTOES_DEF,
  parameter int W         = W_RODADA(N_RODADAS_DEF)
) (
  input  logic [W-1:0]        endereco,
  output logic [N_BOTOES-1:0] gabarito
);

  always_comb begin
    gabarito = '0;
    for (int i = 0; i < N_RODADAS; i++) begin
      if (endereco == W'(i)) gabarito = N_BOTOES'(GABARITO[i % N_RODADAS_DEF]);
    end
  end

endmodule

// File: rtl/quiz_fluxo_dados.sv
// Quiz-game datapath: button capture, answer/key registers, round/hit counters
// and inactivity timer, driven by the control unit's zera/registra/conta strobes.
module quiz_fluxo_dados
  import quiz_pkg::*;
#(
  parameter int N_RODADAS = N_RODADAS_DEF,
  parameter int N_BOTOES  = N_BOTOES_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_BOTOES-1:0]                 botoes,
  input  logic                                zeraR,
  input  logic                                zeraRod,
  input  logic                                zeraA,
  input  logic                                zeraM,
  input  logic                                zeraI,
  input  logic                                registraR,
  input  logic                                registraM,
  input  logic                                contaRod,
  input  logic                                contaA,
  input  logic                                contaI,
  output logic                                jogada_feita,
  output logic                                botaoIgualMemoria,
  output logic                                rodadaIgualFinal,
  output logic                                timeout,
  output logic [W_RODADA(N_RODADAS+1)-1:0]    acertos,
  output logic [W_RODADA(N_RODADAS)-1:0]      rodada,
  output logic [N_BOTOES-1:0]                 db_jogada,
  output logic [N_BOTOES-1:0]                 db_memoria
);

  localparam int W_ROD = W_RODADA(N_RODADAS);
  localparam int W_AC  = W_RODADA(N_RODADAS + 1);
  localparam int W_TMR = W_RODADA(TIMEOUT);

  localparam logic [W_ROD-1:0] ROD_FIM = W_ROD'(N_RODADAS - 1);
  localparam logic [W_AC-1:0]  AC_MAX  = W_AC'(N_RODADAS);
  localparam logic [W_TMR-1:0] TMR_FIM = W_TMR'(TIMEOUT - 1);

  logic [N_BOTOES-1:0] r_s1, r_s2, r_prev, r_cap;
  logic [N_BOTOES-1:0] r_R, r_M;
  logic [W_ROD-1:0]    r_rodada;
  logic [W_AC-1:0]     r_acertos;
  logic                r_pontuado;
  logic [W_TMR-1:0]    r_timer;

  logic [N_BOTOES-1:0] w_gabarito;
  logic                w_jogada;
  logic                w_igual;
  logic                w_pontua;

  quiz_rom #(
    .N_RODADAS (N_RODADAS),
    .N_BOTOES  (N_BOTOES),
    .W         (W_ROD)
  ) u_rom (
    .endereco (r_rodada),
    .gabarito (w_gabarito)
  );

  assign w_jogada = (|r_s2) & ~(|r_prev);
  // A cleared M is all-zero; masking it keeps a cleared R from matching.
  assign w_igual  = (r_R == r_M) && (|r_M);
  assign w_pontua = contaA & w_igual & ~r_pontuado;

  // Synchronizer, edge history and press capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_cap  <= '0;
    end else begin
      r_s1   <= botoes;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (w_jogada) r_cap <= r_s2;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_R <= '0;
      r_M <= '0;
    end else begin
      if (zeraR)          r_R <= '0;
      else if (registraR) r_R <= r_cap;
      if (zeraM)          r_M <= '0;
      else if (registraM) r_M <= w_gabarito;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)                              r_rodada <= '0;
    else if (zeraRod)                        r_rodada <= '0;
    else if (contaRod && r_rodada != ROD_FIM) r_rodada <= r_rodada + 1'b1;
  end

  // pontuado blocks a second score for the same answer until the next registraR
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_acertos  <= '0;
      r_pontuado <= 1'b0;
    end else if (zeraA) begin
      r_acertos  <= '0;
      r_pontuado <= 1'b0;
    end else begin
      if (w_pontua && r_acertos != AC_MAX) r_acertos <= r_acertos + 1'b1;
      if (registraR)     r_pontuado <= 1'b0;
      else if (w_pontua) r_pontuado <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)                          r_timer <= '0;
    else if (zeraI)                      r_timer <= '0;
    else if (contaI && r_timer != TMR_FIM) r_timer <= r_timer + 1'b1;
  end

  assign jogada_feita      = w_jogada;
  assign botaoIgualMemoria = w_igual;
  assign rodadaIgualFinal  = (r_rodada == ROD_FIM);
  assign timeout           = (r_timer == TMR_FIM);
  assign acertos           = r_acertos;
  assign rodada            = r_rodada;
  assign db_jogada         = r_R;
  assign db_memoria        = r_M;

endmodule

// File: tb/tb_quiz_fluxo_dados.sv
// Bench for quiz_fluxo_dados: directed scenarios plus randomized strobes checked
// against a cycle-level model built from the datapath's behavioural rules.
module tb_quiz_fluxo_dados;

  localparam int NR = 16;
  localparam int NB = 4;
  localparam int TO = 8;

  localparam logic [3:0] GAB [NR] = '{
    4'b0100, 4'b0010, 4'b0001, 4'b1000,
    4'b0010, 4'b0100, 4'b1000, 4'b0001,
    4'b0100, 4'b0001, 4'b0010, 4'b1000,
    4'b0001, 4'b1000, 4'b0100, 4'b0010
  };

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [NB-1:0] botoes = '0;
  logic zeraR = 0, zeraRod = 0, zeraA = 0, zeraM = 0, zeraI = 0;
  logic registraR = 0, registraM = 0, contaRod = 0, contaA = 0, contaI = 0;
  logic jogada_feita, botaoIgualMemoria, rodadaIgualFinal, timeout;
  logic [4:0] acertos;
  logic [3:0] rodada;
  logic [NB-1:0] db_jogada, db_memoria;

  int n_pass = 0;
  int n_total = 0;

  // Model state: last three button samples (newest first) and architectural values
  logic [3:0] samp [3];
  logic [3:0] m_R, m_M, m_cap;
  int m_rod, m_ac, m_tmr;
  bit m_pont;

  quiz_fluxo_dados #(.N_RODADAS(NR), .N_BOTOES(NB), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .zeraR(zeraR), .zeraRod(zeraRod), .zeraA(zeraA), .zeraM(zeraM), .zeraI(zeraI),
    .registraR(registraR), .registraM(registraM),
    .contaRod(contaRod), .contaA(contaA), .contaI(contaI),
    .jogada_feita(jogada_feita), .botaoIgualMemoria(botaoIgualMemoria),
    .rodadaIgualFinal(rodadaIgualFinal), .timeout(timeout),
    .acertos(acertos), .rodada(rodada), .db_jogada(db_jogada), .db_memoria(db_memoria)
  );

  always #5 clock = ~clock;

  function automatic bit exp_jog();
    return (samp[1] != 0) && (samp[2] == 0);
  endfunction

  function automatic bit exp_igual();
    return (m_R == m_M) && (m_M != 0);
  endfunction

  // Advance one clock edge and update the model with the inputs held across it
  task automatic step();
    logic [3:0] old_cap;
    bit pressed, hit, scored;
    @(posedge clock);
    if (!reset) begin
      samp[0] = 0; samp[1] = 0; samp[2] = 0;
      m_R = 0; m_M = 0; m_cap = 0;
      m_rod = 0; m_ac = 0; m_tmr = 0; m_pont = 0;
    end else begin
      old_cap = m_cap;
      pressed = exp_jog();
      hit     = exp_igual();
      if (pressed) m_cap = samp[1];
      if (zeraR) m_R = 0; else if (registraR) m_R = old_cap;
      if (zeraM) m_M = 0; else if (registraM) m_M = GAB[m_rod];
      scored = contaA && hit && !m_pont && !zeraA;
      if (zeraA) begin m_ac = 0; m_pont = 0; end
      else begin
        if (scored && m_ac < NR) m_ac++;
        if (registraR) m_pont = 0; else if (scored) m_pont = 1;
      end
      if (zeraRod) m_rod = 0; else if (contaRod && m_rod < NR - 1) m_rod++;
      if (zeraI) m_tmr = 0; else if (contaI && m_tmr < TO - 1) m_tmr++;
      samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = botoes;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; botoes = 4'b0010;
    step(); step();
    n_total++;
    if ({jogada_feita, botaoIgualMemoria, rodadaIgualFinal, timeout, acertos, rodada, db_jogada, db_memoria} !== '0)
      $display("FAIL reset_outputs: got %0h required 0",
               {jogada_feita, botaoIgualMemoria, rodadaIgualFinal, timeout, acertos, rodada, db_jogada, db_memoria});
    else n_pass++;
    reset = 1'b1;
    step();
    n_total++;
    if (jogada_feita !== 1'b0) $display("FAIL reset_pulse_early: got %b required 0", jogada_feita); else n_pass++;
    step();
    n_total++;
    if (jogada_feita !== 1'b1) $display("FAIL reset_pulse: got %b required 1", jogada_feita); else n_pass++;
    step();
    n_total++;
    if (jogada_feita !== 1'b0) $display("FAIL reset_pulse_once: got %b required 0", jogada_feita); else n_pass++;
    botoes = 0;
    repeat (3) step();
  endtask

  task automatic press(input logic [3:0] val);
    botoes = val; step();
    botoes = 0;   step();
    n_total++;
    if (jogada_feita !== 1'b1) $display("FAIL press_pulse: got %b required 1 for %b", jogada_feita, val); else n_pass++;
    step();
  endtask

  task automatic test_correct();
    registraM = 1; step(); registraM = 0;
    n_total++;
    if (db_memoria !== 4'b0100) $display("FAIL correct_mem: got %b required 0100", db_memoria); else n_pass++;
    press(4'b0100);
    registraR = 1; step(); registraR = 0;
    n_total++;
    if (db_jogada !== 4'b0100) $display("FAIL correct_R: got %b required 0100", db_jogada); else n_pass++;
    n_total++;
    if (botaoIgualMemoria !== 1'b1) $display("FAIL correct_cmp: got %b required 1", botaoIgualMemoria); else n_pass++;
    contaA = 1; step(); step(); contaA = 0;
    n_total++;
    if (acertos !== 5'd1) $display("FAIL correct_once: got %0d required 1", acertos); else n_pass++;
  endtask

  task automatic test_wrong();
    press(4'b0001);
    registraR = 1; step(); registraR = 0;
    contaA = 1; step(); contaA = 0;
    n_total++;
    if (db_jogada !== 4'b0001) $display("FAIL wrong_R: got %b required 0001", db_jogada); else n_pass++;
    n_total++;
    if (botaoIgualMemoria !== 1'b0) $display("FAIL wrong_cmp: got %b required 0", botaoIgualMemoria); else n_pass++;
    n_total++;
    if (acertos !== 5'd1) $display("FAIL wrong_hits: got %0d required 1", acertos); else n_pass++;
  endtask

  task automatic test_held_double();
    int pulses;
    pulses = 0;
    botoes = 4'b1000;
    repeat (20) begin step(); pulses += int'(jogada_feita); end
    botoes = 0;
    repeat (3) begin step(); pulses += int'(jogada_feita); end
    n_total++;
    if (pulses !== 1) $display("FAIL held_pulses: got %0d required 1", pulses); else n_pass++;
    contaRod = 1; step(); contaRod = 0;
    registraM = 1; step(); registraM = 0;
    n_total++;
    if (db_memoria !== 4'b0010) $display("FAIL double_mem: got %b required 0010", db_memoria); else n_pass++;
    press(4'b0011);
    registraR = 1; step(); registraR = 0;
    n_total++;
    if (db_jogada !== 4'b0011) $display("FAIL double_cap: got %b required 0011", db_jogada); else n_pass++;
    n_total++;
    if (botaoIgualMemoria !== 1'b0) $display("FAIL double_cmp: got %b required 0", botaoIgualMemoria); else n_pass++;
  endtask

  task automatic test_round();
    zeraRod = 1; contaRod = 1; step(); zeraRod = 0;
    n_total++;
    if (rodada !== 4'd0) $display("FAIL round_clear_wins: got %0d required 0", rodada); else n_pass++;
    repeat (14) step();
    n_total++;
    if (rodadaIgualFinal !== 1'b0) $display("FAIL round_not_final: got %b required 0", rodadaIgualFinal); else n_pass++;
    step();
    n_total++;
    if (rodada !== 4'd15 || rodadaIgualFinal !== 1'b1)
      $display("FAIL round_final: got %0d/%b required 15/1", rodada, rodadaIgualFinal);
    else n_pass++;
    step(); contaRod = 0;
    n_total++;
    if (rodada !== 4'd15) $display("FAIL round_saturate: got %0d required 15", rodada); else n_pass++;
  endtask

  task automatic test_timer();
    zeraI = 1; step(); zeraI = 0;
    contaI = 1;
    repeat (6) step();
    n_total++;
    if (timeout !== 1'b0) $display("FAIL timer_early: got %b required 0", timeout); else n_pass++;
    step();
    n_total++;
    if (timeout !== 1'b1) $display("FAIL timer_reach: got %b required 1", timeout); else n_pass++;
    repeat (3) step();
    n_total++;
    if (timeout !== 1'b1) $display("FAIL timer_hold: got %b required 1", timeout); else n_pass++;
    zeraI = 1; step(); zeraI = 0;
    n_total++;
    if (timeout !== 1'b0) $display("FAIL timer_clear: got %b required 0", timeout); else n_pass++;
    repeat (6) step();
    contaI = 0;
    n_total++;
    if (timeout !== 1'b0) $display("FAIL timer_restart: got %b required 0", timeout); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] onehot;
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 60) != 0);
      zeraR     = ($urandom_range(0, 9) == 0);
      zeraRod   = ($urandom_range(0, 19) == 0);
      zeraA     = ($urandom_range(0, 29) == 0);
      zeraM     = ($urandom_range(0, 14) == 0);
      zeraI     = ($urandom_range(0, 9) == 0);
      registraR = ($urandom_range(0, 3) == 0);
      registraM = ($urandom_range(0, 3) == 0);
      contaRod  = ($urandom_range(0, 3) == 0);
      contaA    = ($urandom_range(0, 1) == 0);
      contaI    = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0) begin
        onehot = 4'b0001 << $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          0, 1:    botoes = 0;
          2:       botoes = onehot;
          default: botoes = 4'($urandom_range(0, 15));
        endcase
      end
      step();
      n_total++;
      if ({jogada_feita, botaoIgualMemoria, rodadaIgualFinal, timeout} !==
          {exp_jog(), exp_igual(), m_rod == NR - 1, m_tmr == TO - 1} ||
          acertos !== 5'(m_ac) || rodada !== 4'(m_rod) || db_jogada !== m_R || db_memoria !== m_M)
        $display("FAIL random_c%0d: got jf=%b eq=%b fin=%b to=%b ac=%0d rod=%0d R=%b M=%b required jf=%b eq=%b fin=%b to=%b ac=%0d rod=%0d R=%b M=%b",
                 c, jogada_feita, botaoIgualMemoria, rodadaIgualFinal, timeout, acertos, rodada, db_jogada, db_memoria,
                 exp_jog(), exp_igual(), m_rod == NR - 1, m_tmr == TO - 1, m_ac, m_rod, m_R, m_M);
      else n_pass++;
    end
    reset = 1'b1;
    {zeraR, zeraRod, zeraA, zeraM, zeraI, registraR, registraM, contaRod, contaA, contaI} = '0;
    botoes = 0;
  endtask

  initial begin
    samp[0] = 0; samp[1] = 0; samp[2] = 0;
    m_R = 0; m_M = 0; m_cap = 0; m_rod = 0; m_ac = 0; m_tmr = 0; m_pont = 0;
    test_reset();
    test_correct();
    test_wrong();
    test_held_double();
    test_round();
    test_timer();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/quiz_fluxo_dados.md
# quiz_fluxo_dados

Datapath that answers the quiz-game control unit. It decodes the control unit's zera/registra/conta strobes into its registers and counters, and returns the status flags the FSM branches on: `jogada_feita`, `botaoIgualMemoria` and `rodadaIgualFinal`. It owns these elements:
- button synchronizer and edge detector
- answer-key memory and expected-answer register
- player-answer register
- round counter, hit counter and inactivity timer

## Interface
- `N_RODADAS`, default 16: rounds per game; the round counter is `$clog2(N_RODADAS)` bits wide.
- `N_BOTOES`, default 4: answer buttons; all answers are one-hot of this width.
- `TIMEOUT`, default 5000: inactivity-timer terminal count, in clock cycles.
- `clock`  in  1  system clock; every register updates on its rising edge.
- `reset`  in  1  reset, synchronous and active-low.
- `botoes`  in  N_BOTOES  raw asynchronous buttons, active-high.
- `zeraR, zeraRod, zeraA, zeraM, zeraI`  in  1 each  clear the answer register, round counter, hit counter, memory register and timer.
- `registraR, registraM`  in  1 each  load the answer register and the memory register.
- `contaRod, contaA, contaI`  in  1 each  advance the round counter, hit counter and timer.
- `jogada_feita`  out  1  one-cycle pulse on a new button press.
- `botaoIgualMemoria`  out  1  answer register equals memory register.
- `rodadaIgualFinal`  out  1  round counter equals `N_RODADAS-1`.
- `timeout`  out  1  inactivity timer has reached `TIMEOUT-1`.
- `acertos`  out  `$clog2(N_RODADAS+1)`  hit count.
- `rodada`  out  `$clog2(N_RODADAS)`  current round.
- `db_jogada, db_memoria`  out  N_BOTOES each  contents of the answer register and the memory register.

## Operation
- **Reset value.** While `reset`=0 at a clock edge, every register clears to 0. Every output is then 0, except `rodadaIgualFinal`, which reads 1 only when `N_RODADAS`=1.
- **Priority.** Per register, zera beats registra, which beats conta.
- **Synchronizer.** Two flops: `s1`<=`botoes`, then `s2`<=`s1`. A third flop holds `prev`<=`s2`.
- **Press detection.** `jogada_feita` = `|s2 & ~|prev`. It pulses once per press, no matter how long the button is held, and cannot re-fire until every button has been released.
- **Capture register `cap`.** Loads `s2` in the same cycle `jogada_feita` is high, so the player may release the button before `registraR` arrives.
- **Multiple buttons.** If several buttons are pressed in the same cycle, the multi-hot value is captured unchanged. It can never equal a one-hot key, so it scores as a miss.
- **Answer register R.** `registraR` copies `cap` into R; `zeraR` clears R.
- **Memory register M.** `registraM` loads `gabarito[rodada]` from `quiz_rom`; `zeraM` clears M.
- **Compare.** `botaoIgualMemoria` = (R == M) && (M != 0). The flag is therefore 0 after a clear.
- **Round counter.**
  - `contaRod` increments it; it saturates at `N_RODADAS-1` and never wraps.
  - `zeraRod` clears it.
  - `rodadaIgualFinal` is combinational from the counter.
- **Hit counter.** `contaA` increments it only when `botaoIgualMemoria`=1 and the `pontuado` flag is clear; the increment sets `pontuado`. `registraR` or `zeraA` clears `pontuado`. This way an FSM that holds `contaA` for two consecutive states scores each answer at most once. The counter saturates at `N_RODADAS`.
- **Inactivity timer.** `contaI` increments it; it saturates at `TIMEOUT-1`, and `timeout` is asserted there. `zeraI` clears it.

## Timing
- **Button to pulse.** `botoes` first sampled high at edge t, then held: `s2` is high after edge t+1, and `jogada_feita` is high for exactly the one cycle between edges t+1 and t+2. `cap` is valid after edge t+2.
- **Register updates.** `registraR` or `registraM` at edge k: the new R or M is visible after edge k, and `botaoIgualMemoria` reflects it combinationally in the same cycle.
- **Counters.** Any count or clear strobe takes effect at the next edge; every counter output is registered.
- **Simultaneous events.**
  - A press in the same cycle as `zeraR`: `cap` still loads; only R clears.
  - `contaRod` with `zeraRod`: the clear wins.
  - `registraR` with `contaA`: the increment uses the old R; `pontuado` ends cleared.
- **Reset mid-game.** Reset clears all state at that edge, including `s1`, `s2`, `prev`, `cap` and `pontuado`. A button held through reset produces one `jogada_feita` two cycles after reset is released.

## Structure
- **Package `quiz_pkg`:**
  - constants `N_BOTOES_DEF`, `N_RODADAS_DEF`, `TIMEOUT_DEF`;
  - width function `$clog2`-based `W_RODADA`;
  - the answer-key constant array `GABARITO` of `N_RODADAS` one-hot entries.
- **Sub-module `quiz_rom`:** combinational `endereco` -> `gabarito` lookup indexed by `rodada`. It is separate so that a different question set is a ROM swap only.
- **Top module:** all registers and counters stay in `quiz_fluxo_dados`.

## Test plan
- **Reset value.** Hold `reset`=0 for 2 cycles with `botoes`=4'b0010, then release. -> All outputs are 0 during reset, and `jogada_feita` pulses once, 2 cycles after release.
- **Correct answer.**
  - `GABARITO[0]`=4'b0100: pulse `registraM`, press 4'b0100 for 1 cycle, then pulse `registraR`.
  - Expect `db_jogada`=4'b0100 and `botaoIgualMemoria`=1.
  - Then assert `contaA` for 2 cycles -> `acertos`=1, not 2.
- **Wrong answer.** Press 4'b0001 against M=4'b0100, then `registraR` and `contaA`. -> `botaoIgualMemoria`=0 and `acertos` unchanged.
- **Held and double press.** Hold 4'b1000 for 20 cycles -> exactly one `jogada_feita`. Press 4'b0011 -> a pulse, the captured value is 4'b0011, and the compare with M=4'b0010 is 0.
- **Round boundary.** Pulse `contaRod` 15 times with `N_RODADAS`=16 -> `rodada`=15 and `rodadaIgualFinal`=1. A 16th pulse leaves `rodada`=15.
- **Timer.** `TIMEOUT`=8: hold `contaI` -> `timeout`=1 after the 7th edge and stays there. Assert `zeraI` together with `contaI` -> the timer is 0 and `timeout`=0 at the next edge.
